// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous 8-bit RAM between a video reader and a CPU.
// Fixed three-cycle access: sample request, issue to RAM, capture read data and acknowledge.
module ram_arbiter #(
    parameter int KB = 16,
    localparam int AW = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic          vack,
    output logic [7:0]    vq,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cd,
    output logic          cack,
    output logic [7:0]    cq,
    output logic          wait_n,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    logic   grant_cpu;
    logic   lat_wr;
    logic   last_cpu;
    logic   pick_cpu;

    // Video wins a tie unless it also won the previous grant, so the CPU never waits more than one video access.
    assign pick_cpu = creq & (~vreq | ~last_cpu);

    assign wait_n = ~(creq & ~cack);

    // Access sequencer; ram_a and ram_d double as the latched address and write data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_cpu <= 1'b0;
            lat_wr    <= 1'b0;
            last_cpu  <= 1'b1;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b1;
            ram_a     <= {AW{1'b0}};
            ram_d     <= 8'h00;
            vack      <= 1'b0;
            cack      <= 1'b0;
            vq        <= 8'h00;
            cq        <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    vack <= 1'b0;
                    cack <= 1'b0;
                    if (vreq || creq) begin
                        state     <= ISSUE;
                        ram_ce    <= 1'b1;
                        grant_cpu <= pick_cpu;
                        last_cpu  <= pick_cpu;
                        if (pick_cpu) begin
                            ram_a  <= ca;
                            ram_we <= ~cwr;
                            lat_wr <= cwr;
                            if (cwr) begin
                                ram_d <= cd;
                            end
                        end else begin
                            ram_a  <= va;
                            ram_we <= 1'b1;
                            lat_wr <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    ram_ce <= 1'b0;
                    ram_we <= 1'b1;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                    if (grant_cpu) begin
                        cack <= 1'b1;
                        if (!lat_wr) begin
                            cq <= ram_q;
                        end
                    end else begin
                        vack <= 1'b1;
                        vq   <= ram_q;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_ce <= 1'b0;
                    ram_we <= 1'b1;
                    vack   <= 1'b0;
                    cack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural synchronous RAM, a table of single
// transactions, and hand-written sequences for contention, reset abort and idle bus.
module tb_ram_arbiter;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          vreq;
    logic [AW-1:0] va;
    logic          vack;
    logic [7:0]    vq;
    logic          creq;
    logic          cwr;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
    logic          cack;
    logic [7:0]    cq;
    logic          wait_n;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic [7:0]    ram_q;

    logic [7:0] mem [0:(1<<AW)-1];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic          cpu;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } vec_t;

    vec_t vecs [0:8];
    logic [7:0] exp_vq;
    logic [7:0] exp_cq;

    ram_arbiter #(.KB(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .vreq   (vreq),
        .va     (va),
        .vack   (vack),
        .vq     (vq),
        .creq   (creq),
        .cwr    (cwr),
        .ca     (ca),
        .cd     (cd),
        .cack   (cack),
        .cq     (cq),
        .wait_n (wait_n),
        .ram_ce (ram_ce),
        .ram_we (ram_we),
        .ram_a  (ram_a),
        .ram_d  (ram_d),
        .ram_q  (ram_q)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: read data valid the cycle after an enabled read edge.
    always @(posedge clock) begin
        if (ram_ce) begin
            if (!ram_we) begin
                mem[ram_a] <= ram_d;
            end else begin
                ram_q <= mem[ram_a];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'h00;
        end
        mem[14'h1234] = 8'hA5;
        mem[14'h0010] = 8'h77;
        ram_q = 8'h00;

        vecs[0] = '{1'b0, 1'b0, 14'h1234, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 14'h0400, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 14'h0400, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 14'h3FFF, 8'hFF};
        vecs[4] = '{1'b0, 1'b0, 14'h3FFF, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 14'h0000, 8'h5A};
        vecs[6] = '{1'b1, 1'b0, 14'h0000, 8'h5A};
        vecs[7] = '{1'b0, 1'b0, 14'h0400, 8'h3C};
        vecs[8] = '{1'b1, 1'b0, 14'h1234, 8'hA5};

        reset = 1'b1;
        vreq  = 1'b0;
        creq  = 1'b0;
        cwr   = 1'b0;
        va    = 14'h0000;
        ca    = 14'h0000;
        cd    = 8'h00;
        exp_vq = 8'h00;
        exp_cq = 8'h00;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ram_ce", ram_ce, 1'b0);
        check("rst_ram_we", ram_we, 1'b1);
        check("rst_ram_a", ram_a, 14'h0000);
        check("rst_ram_d", ram_d, 8'h00);
        check("rst_vack", vack, 1'b0);
        check("rst_cack", cack, 1'b0);
        check("rst_vq", vq, 8'h00);
        check("rst_cq", cq, 8'h00);
        check("rst_wait_n", wait_n, 1'b1);
        reset = 1'b0;

        // Single transactions; address/data are scrambled after sampling to prove latching.
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (vecs[i].cpu) begin
                creq = 1'b1;
                cwr  = vecs[i].wr;
                ca   = vecs[i].addr;
                cd   = vecs[i].wr ? vecs[i].data : 8'h00;
            end else begin
                vreq = 1'b1;
                va   = vecs[i].addr;
            end
            @(negedge clock);
            vreq = 1'b0;
            va   = ~vecs[i].addr;
            ca   = ~vecs[i].addr;
            cd   = ~vecs[i].data;
            check("issue_ce", ram_ce, 1'b1);
            check("issue_we", ram_we, !(vecs[i].cpu && vecs[i].wr));
            check("issue_a", ram_a, vecs[i].addr);
            if (vecs[i].cpu && vecs[i].wr) begin
                check("issue_d", ram_d, vecs[i].data);
            end
            check("issue_wait_n", wait_n, !vecs[i].cpu);
            @(negedge clock);
            check("capture_ce", ram_ce, 1'b0);
            check("capture_we", ram_we, 1'b1);
            check("capture_vack", vack, 1'b0);
            check("capture_cack", cack, 1'b0);
            @(negedge clock);
            if (!vecs[i].cpu) begin
                exp_vq = vecs[i].data;
            end else if (!vecs[i].wr) begin
                exp_cq = vecs[i].data;
            end
            check("ack_vack", vack, !vecs[i].cpu);
            check("ack_cack", cack, vecs[i].cpu);
            check("ack_vq", vq, exp_vq);
            check("ack_cq", cq, exp_cq);
            check("ack_wait_n", wait_n, 1'b1);
            creq = 1'b0;
            @(negedge clock);
            check("post_vack", vack, 1'b0);
            check("post_cack", cack, 1'b0);
            check("post_vq", vq, exp_vq);
            check("post_cq", cq, exp_cq);
        end

        // Contention right after reset: video first, CPU follows at E3, cack at E5.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vreq = 1'b1;
        va   = 14'h1234;
        creq = 1'b1;
        cwr  = 1'b0;
        ca   = 14'h0400;
        @(negedge clock);
        check("both_e0_a", ram_a, 14'h1234);
        check("both_e0_we", ram_we, 1'b1);
        check("both_e0_wait_n", wait_n, 1'b0);
        @(negedge clock);
        check("both_e1_wait_n", wait_n, 1'b0);
        @(negedge clock);
        check("both_e2_vack", vack, 1'b1);
        check("both_e2_vq", vq, 8'hA5);
        check("both_e2_cack", cack, 1'b0);
        check("both_e2_wait_n", wait_n, 1'b0);
        vreq = 1'b0;
        @(negedge clock);
        check("both_e3_ce", ram_ce, 1'b1);
        check("both_e3_a", ram_a, 14'h0400);
        check("both_e3_vack", vack, 1'b0);
        check("both_e3_wait_n", wait_n, 1'b0);
        @(negedge clock);
        check("both_e4_wait_n", wait_n, 1'b0);
        @(negedge clock);
        check("both_e5_cack", cack, 1'b1);
        check("both_e5_cq", cq, 8'h3C);
        check("both_e5_wait_n", wait_n, 1'b1);
        creq = 1'b0;
        @(negedge clock);
        check("both_e6_cack", cack, 1'b0);

        // Both requests held: grants must alternate V,C,V,C,...
        vreq = 1'b1;
        va   = 14'h1234;
        creq = 1'b1;
        cwr  = 1'b0;
        ca   = 14'h0400;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("alt_ce", ram_ce, 1'b1);
            check("alt_grant_a", ram_a, (k % 2 == 0) ? 14'h1234 : 14'h0400);
            repeat (2) @(negedge clock);
        end
        check("alt_last_cack", cack, 1'b1);
        vreq = 1'b0;
        creq = 1'b0;
        @(negedge clock);
        check("alt_drained_ce", ram_ce, 1'b0);

        // Reset during ISSUE of a CPU write aborts it before the RAM edge.
        @(negedge clock);
        creq = 1'b1;
        cwr  = 1'b1;
        ca   = 14'h0010;
        cd   = 8'h99;
        @(posedge clock);
        #2;
        check("abort_issue_ce", ram_ce, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_we", ram_we, 1'b1);
        check("abort_ce", ram_ce, 1'b0);
        check("abort_a", ram_a, 14'h0000);
        check("abort_d", ram_d, 8'h00);
        creq = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_mem", mem[14'h0010], 8'h77);
        check("abort_cack", cack, 1'b0);
        check("abort_vq", vq, 8'h00);
        check("abort_cq", cq, 8'h00);
        vreq = 1'b1;
        va   = 14'h1234;
        @(negedge clock);
        check("first_edge_ce", ram_ce, 1'b1);
        check("first_edge_a", ram_a, 14'h1234);
        check("first_edge_cack", cack, 1'b0);
        vreq = 1'b0;
        @(negedge clock);
        check("first_edge_cack2", cack, 1'b0);
        @(negedge clock);
        check("first_edge_vack", vack, 1'b1);
        check("first_edge_vq", vq, 8'hA5);
        check("first_edge_cack3", cack, 1'b0);
        @(negedge clock);

        // Idle bus.
        repeat (10) begin
            @(negedge clock);
            check("idle_ce", ram_ce, 1'b0);
            check("idle_vack", vack, 1'b0);
            check("idle_cack", cack, 1'b0);
            check("idle_wait_n", wait_n, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL take parameter KB, default 16: RAM size in KiB; AW = clog2(KB*1024).
REQ-002 SHALL have port clock, input, 1 bit: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port vreq, input, 1 bit: video read request, level.
REQ-005 SHALL have port va, input, AW bits: video read address.
REQ-006 SHALL have port vack, output, 1 bit: one-cycle pulse, vq valid.
REQ-007 SHALL have port vq, output, 8 bits: video read data.
REQ-008 SHALL have port creq, input, 1 bit: CPU request, level.
REQ-009 SHALL have port cwr, input, 1 bit: CPU access type, 1 = write, 0 = read.
REQ-010 SHALL have port ca, input, AW bits: CPU address.
REQ-011 SHALL have port cd, input, 8 bits: CPU write data.
REQ-012 SHALL have port cack, output, 1 bit: one-cycle pulse, CPU access complete.
REQ-013 SHALL have port cq, output, 8 bits: CPU read data.
REQ-014 SHALL have port wait_n, output, 1 bit: low while a CPU request is pending and unacknowledged.
REQ-015 SHALL have port ram_ce, output, 1 bit: RAM enable.
REQ-016 SHALL have port ram_we, output, 1 bit: RAM write strobe, active-low (0 = write, 1 = read).
REQ-017 SHALL have port ram_a, output, AW bits: RAM address.
REQ-018 SHALL have port ram_d, output, 8 bits: RAM write data.
REQ-019 SHALL have port ram_q, input, 8 bits: RAM read data, valid the cycle after the RAM samples an enabled read.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, CAPTURE; all ram_* outputs and acks registered.
REQ-021 IDLE: at an edge with vreq or creq high, SHALL latch the grant, address, type and data, and enter ISSUE.
REQ-022 ISSUE (one cycle): ram_ce=1, ram_a/ram_we/ram_d from the latched grant; next state CAPTURE.
REQ-023 Outside ISSUE: ram_ce=0 and ram_we=1; ram_a/ram_d hold their last values.
REQ-024 CAPTURE (one cycle): at its closing edge, on a read SHALL load ram_q into vq or cq and pulse the matching ack for exactly one cycle; next state IDLE.
REQ-025 Latency SHALL be fixed: request sampled at edge E0; RAM access at E1; ack high from E2 to E3.
REQ-026 CPU write SHALL drive ram_we=0 and ram_d=cd in ISSUE, pulse cack at E2, and leave cq unchanged.
REQ-027 Video access SHALL always be a read; ram_we=1 for video grants.
REQ-028 Requesters SHALL drop req by edge E3; req still high at E3 SHALL be treated as a new request.
REQ-029 Simultaneous vreq and creq in IDLE: video SHALL win, unless the previous grant was video and creq is high; then CPU wins, alternating.
REQ-030 CPU wait SHALL be bounded to one video access (at most 3 extra cycles).
REQ-031 wait_n SHALL equal NOT(creq AND NOT cack), combinational on registered cack.
REQ-032 Address/data changes while not in IDLE SHALL be ignored; the latched values are used.
REQ-033 vq and cq SHALL hold their values between acks.

Reset
REQ-034 reset high SHALL immediately force: state IDLE; ram_ce=0, ram_we=1, ram_a=0, ram_d=0; vack=0, cack=0; vq=0, cq=0; last-grant=CPU (video first after reset).
REQ-035 Reset in ISSUE or CAPTURE SHALL abort the access: no ack, and no RAM write after reset asserts.
REQ-036 After reset deasserts, the first request SHALL be sampled at the first rising edge.

Verification
REQ-037 Video read, RAM[0x1234]=0xA5, vreq pulsed at E0 -> ram_ce=1/ram_we=1/ram_a=0x1234 in E0-E1; vack=1 and vq=0xA5 in E2-E3.
REQ-038 CPU write ca=0x0400, cd=0x3C, then CPU read 0x0400 -> second cack with cq=0x3C; ram_we=0 only during the write's ISSUE.
REQ-039 vreq and creq both high at E0 -> video served first (vack at E2); CPU ISSUE starts at E3, cack at E5; wait_n low E0-E5.
REQ-040 vreq held continuously and creq held -> grants alternate V,C,V,C; no creq waits more than one video access.
REQ-041 Reset asserted mid-ISSUE of CPU write to 0x0010 -> no cack; ram_we=1 immediately; RAM[0x0010] unchanged if reset precedes the E1 edge.
REQ-042 Idle bus for 10 cycles -> ram_ce stays 0; acks stay 0; wait_n=1.
